vrf_writeback: RTL and testbench
================================

# vrf_writeback

Write-back engine for the vector register file: it accepts results from the vector execution stage on a valid/ready handshake and queues them in a small FIFO. It then writes each one into the single-port VRF RAM whenever the operand-read sequencer leaves the port free. Per-element masked writes are performed as read-modify-write. Address hazards against queued results are flagged so the operand reader stalls instead of fetching stale data.

## Interface
- DataWidth, 128, vector register width in bits
- AddrWidth, 5, VRF address width (2**AddrWidth registers)
- ElemWidth, 32, mask granularity; DataWidth must be a multiple of ElemWidth; NumElem = DataWidth/ElemWidth
- FifoDepth, 2, result queue entries, minimum 1

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wb_valid_i  in  1  result valid
- wb_ready_o  out  1  result accepted when valid and ready are both high
- wb_addr_i  in  AddrWidth  destination register
- wb_data_i  in  DataWidth  result data
- wb_mask_i  in  NumElem  element write enables; bit i covers bits [i*ElemWidth +: ElemWidth]
- ram_gnt_i  in  1  RAM port free this cycle (reader idle)
- ram_req_o  out  1  RAM access request, only asserted when ram_gnt_i is high
- ram_we_o  out  1  1 = write, 0 = read
- ram_addr_o  out  AddrWidth  RAM address
- ram_wdata_o  out  DataWidth  RAM write data
- ram_rdata_i  in  DataWidth  RAM read data, valid the cycle after a read request
- hazard_addr_i  in  AddrWidth  address the reader is about to fetch
- hazard_o  out  1  hazard_addr_i matches a queued or in-flight entry
- busy_o  out  1  FIFO non-empty or FSM not idle

## Operation
- FIFO entry: {addr, data, mask}. wb_ready_o = !full. Push on handshake. Pop only when the head's RAM write is issued, or when the head is discarded.
- FSM states: WB_IDLE, WB_RMW_RD, WB_RMW_WR.
- WB_IDLE with FIFO non-empty:
  - mask == 0: pop without RAM access; no grant needed.
  - mask all-ones and ram_gnt_i: full write (req=1, we=1, addr/data from head); pop; stay in WB_IDLE.
  - partial mask and ram_gnt_i: issue read of head addr; go to WB_RMW_RD.
  - ram_gnt_i low: hold.
- WB_RMW_RD: latch ram_rdata_i into old_q unconditionally; go to WB_RMW_WR.
- WB_RMW_WR: when ram_gnt_i is high, write merge(old_q, head.data, head.mask), pop, go to WB_IDLE; otherwise hold.
- Merge: element i = mask[i] ? new : old.
- hazard_o: combinational OR over all valid FIFO entries of (entry.addr == hazard_addr_i). The head counts until popped. The same-cycle incoming wb_addr_i is not included.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged. When full, no push is accepted in the same cycle as a pop (no bypass).
- Reset: FIFO is cleared and FSM goes to WB_IDLE. old_q is cleared to 0. An in-progress RMW is abandoned with no write issued. RAM data returned after reset is ignored.

## Timing
- Reset values: wb_ready_o=1, ram_req_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, hazard_o=0, busy_o=0.
- Accept at cycle T, entry is visible at the head at T+1.
- Full write: earliest at T+1.
- RMW: read at T+1, latch at T+2, write at T+2+k, where k ≥ 1 is the cycle on which ram_gnt_i is first high from T+2 onward.
- Full-mask throughput: 1 write/cycle under continuous grant.
- RMW throughput: 1 per 3 cycles minimum.
- ram_req_o, ram_we_o, ram_addr_o and ram_wdata_o are combinational from state, head and ram_gnt_i. ram_wdata_o is 0 when ram_req_o is low.
- Grant drops during WB_RMW_RD: no effect, because the read was already issued.

## Configuration
- VRF_WB_MASK_EN defined:
  - masks honored as above, including RMW states.
  - hazard against masked entries included.
- Undefined:
  - wb_mask_i is ignored.
  - every entry is written in full.
  - WB_RMW_RD, WB_RMW_WR and old_q are not compiled.
  - mask == 0 entries are written in full, not discarded.

## Structure
- Package vrf_pkg holds:
  - vrf_wb_state_t enum.
  - vrf_wb_entry_t struct, parameterized by the package constants VRF_DATA_W=128, VRF_ADDR_W=5, VRF_ELEM_W=32.
- Sub-module vrf_wb_fifo contains:
  - the storage, pointers and count, with push/pop/full/empty.
  - a flat per-entry valid and address vector exported for the hazard compare.

## Test plan
- Reset, then push {addr=3, data=0xA5..A5, mask=4'hF} with grant always high -> at T+1 ram_req=1, we=1, addr=3, wdata=0xA5..A5; busy_o low at T+2.
- RAM reg 7 preloaded with 0x11111111_22222222_33333333_44444444; push {addr=7, data=all 0xFF, mask=4'b0101} -> read at T+1, write at T+3 of 0x11111111_FFFFFFFF_33333333_FFFFFFFF.
- Hold ram_gnt_i low and push 3 entries with FifoDepth=2 -> wb_ready_o low after 2 accepts. Raise grant -> writes issued in order; ready rises on the first pop.
- Queue addr=9 and drive hazard_addr_i=9 -> hazard_o=1 until the write cycle, 0 the cycle after. hazard_addr_i=10 -> hazard_o=0 throughout.
- Assert rst_i in WB_RMW_WR while grant is low -> no write issued, all outputs at reset values, RAM content unchanged.
- mask=4'b0000 push -> popped in 1 cycle with ram_req_o never high (VRF_WB_MASK_EN defined); written in full when undefined.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types for the VRF write-back engine: FSM states and the queued result entry.
// The RMW states are only used when VRF_WB_MASK_EN is defined.
package vrf_pkg;

    localparam int VRF_DATA_W   = 128;
    localparam int VRF_ADDR_W   = 5;
    localparam int VRF_ELEM_W   = 32;
    localparam int VRF_NUM_ELEM = VRF_DATA_W / VRF_ELEM_W;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_RMW_RD = 2'd1,
        WB_RMW_WR = 2'd2
    } vrf_wb_state_t;

    typedef struct packed {
        logic [VRF_ADDR_W-1:0]   addr;
        logic [VRF_DATA_W-1:0]   data;
        logic [VRF_NUM_ELEM-1:0] mask;
    } vrf_wb_entry_t;

endpackage

// File: rtl/vrf_wb_fifo.sv
// Result queue for the write-back engine, with per-slot valid/address export
// so the top can flag reader hazards against every queued entry.
module vrf_wb_fifo
    import vrf_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  vrf_wb_entry_t               entry_i,
    input  logic                        pop_i,
    output vrf_wb_entry_t               head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [Depth-1:0]            valid_o,
    output logic [Depth*VRF_ADDR_W-1:0] addr_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    vrf_wb_entry_t   mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [Depth-1:0] valid_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;

    always_comb begin
        addr_o = '0;
        for (int j = 0; j < Depth; j++) begin
            addr_o[j*VRF_ADDR_W +: VRF_ADDR_W] = mem_q[j].addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < Depth; j++) begin
                mem_q[j] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q]   <= entry_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vrf_writeback.sv
// VRF write-back engine: queues execution results and writes them into the shared RAM port.
// Define VRF_WB_MASK_EN to honour element masks (read-modify-write); otherwise every entry is written in full.
module vrf_writeback
    import vrf_pkg::*;
#(
    parameter int DataWidth = VRF_DATA_W,
    parameter int AddrWidth = VRF_ADDR_W,
    parameter int ElemWidth = VRF_ELEM_W,
    parameter int FifoDepth = 2,
    localparam int NumElem  = DataWidth / ElemWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_valid_i,
    output logic                 wb_ready_o,
    input  logic [AddrWidth-1:0] wb_addr_i,
    input  logic [DataWidth-1:0] wb_data_i,
    input  logic [NumElem-1:0]   wb_mask_i,
    input  logic                 ram_gnt_i,
    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [DataWidth-1:0] ram_wdata_o,
    input  logic [DataWidth-1:0] ram_rdata_i,
    input  logic [AddrWidth-1:0] hazard_addr_i,
    output logic                 hazard_o,
    output logic                 busy_o
);
    vrf_wb_entry_t                    in_entry, head;
    logic                             push, pop, full, empty;
    logic [FifoDepth-1:0]             ent_valid;
    logic [FifoDepth*AddrWidth-1:0]   ent_addr;

    assign wb_ready_o    = !full;
    assign push          = wb_valid_i && !full;
    assign in_entry.addr = wb_addr_i;
    assign in_entry.data = wb_data_i;
    assign in_entry.mask = wb_mask_i;

    vrf_wb_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i (in_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .valid_o (ent_valid),
        .addr_o  (ent_addr)
    );

    // Head stays visible to the reader until the cycle its write is issued.
    always_comb begin
        hazard_o = 1'b0;
        for (int j = 0; j < FifoDepth; j++) begin
            if (ent_valid[j] && (ent_addr[j*AddrWidth +: AddrWidth] == hazard_addr_i)) begin
                hazard_o = 1'b1;
            end
        end
    end

`ifdef VRF_WB_MASK_EN
    localparam logic [NumElem-1:0] FullMask = '1;

    vrf_wb_state_t          state_q, state_d;
    logic [DataWidth-1:0]   old_q;
    logic [DataWidth-1:0]   merged;

    always_comb begin
        merged = '0;
        for (int i = 0; i < NumElem; i++) begin
            merged[i*ElemWidth +: ElemWidth] = head.mask[i] ? head.data[i*ElemWidth +: ElemWidth]
                                                            : old_q[i*ElemWidth +: ElemWidth];
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        case (state_q)
            WB_IDLE: begin
                if (!empty) begin
                    if (head.mask == '0) begin
                        pop = 1'b1;
                    end else if (ram_gnt_i) begin
                        ram_req_o  = 1'b1;
                        ram_addr_o = head.addr;
                        if (head.mask == FullMask) begin
                            ram_we_o    = 1'b1;
                            ram_wdata_o = head.data;
                            pop         = 1'b1;
                        end else begin
                            state_d = WB_RMW_RD;
                        end
                    end
                end
            end
            WB_RMW_RD: state_d = WB_RMW_WR;
            WB_RMW_WR: begin
                if (ram_gnt_i) begin
                    ram_req_o   = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_addr_o  = head.addr;
                    ram_wdata_o = merged;
                    pop         = 1'b1;
                    state_d     = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WB_IDLE;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == WB_RMW_RD) begin
                old_q <= ram_rdata_i;
            end
        end
    end

    assign busy_o = !empty || (state_q != WB_IDLE);
`else
    logic unused_mask;

    assign pop         = !empty && ram_gnt_i;
    assign ram_req_o   = pop;
    assign ram_we_o    = pop;
    assign ram_addr_o  = pop ? head.addr : '0;
    assign ram_wdata_o = pop ? head.data : '0;
    assign busy_o      = !empty;
    assign unused_mask = ^{head.mask, ram_rdata_i};
`endif

endmodule

// File: tb/tb_vrf_writeback.sv
// Directed bench for vrf_writeback; mask-dependent expectations follow VRF_WB_MASK_EN.
module tb_vrf_writeback;
    localparam int DW = 128;
    localparam int AW = 5;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [NE-1:0] wb_mask;
    logic          ram_gnt, ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [AW-1:0] haz_addr;
    logic          hazard, busy;

    logic [DW-1:0] ram [32];
    int            wr_cnt = 0;
    logic          bad_req = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    vrf_writeback #(.DataWidth(DW), .AddrWidth(AW), .ElemWidth(32), .FifoDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_mask_i(wb_mask),
        .ram_gnt_i(ram_gnt), .ram_req_o(ram_req), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .hazard_addr_i(haz_addr), .hazard_o(hazard), .busy_o(busy)
    );

    // Single-port RAM: write on request, read data returned the following cycle.
    always @(posedge clk) begin
        if (ram_req && !ram_gnt) bad_req <= 1'b1;
        if (ram_req && ram_we) begin
            ram[ram_addr] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (ram_req && !ram_we) ram_rdata <= ram[ram_addr];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_ready"}, wb_ready, 1'b1);
        chk1({tag, "_req"}, ram_req, 1'b0);
        chk1({tag, "_we"}, ram_we, 1'b0);
        chka({tag, "_addr"}, ram_addr, '0);
        chkd({tag, "_wdata"}, ram_wdata, '0);
        chk1({tag, "_hazard"}, hazard, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    logic [DW-1:0] d_a5, d_ff, r7, r12, r14, merged7;
    logic [DW-1:0] d4, d5, d6, d9, d12, d14, d20, d21, d22;
    int            wr_snap;

    initial begin
        d_a5    = {16{8'hA5}};
        d_ff    = {DW{1'b1}};
        r7      = 128'h11111111_22222222_33333333_44444444;
        merged7 = 128'h11111111_FFFFFFFF_33333333_FFFFFFFF;
        r12     = 128'hC0C0_0000_0000_0000_0000_0000_0000_0C0C;
        r14     = 128'h0E0E_0E0E_0000_0000_0000_0000_1414_1414;
        d4  = 128'h4;  d5  = 128'h55;  d6  = 128'h666;  d9  = 128'h9999;
        d12 = 128'hDEAD_BEEF; d14 = 128'h1234_5678_9ABC; d20 = 128'h20; d21 = 128'h2121; d22 = 128'h222222;
        for (int i = 0; i < 32; i++) ram[i] = '0;
        ram[7]  = r7;
        ram[12] = r12;
        ram[14] = r14;
        ram_rdata = '0;

        rst = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_mask = '0;
        ram_gnt = 1'b1; haz_addr = 5'd31;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Full-mask write, grant always high
        tick();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = d_a5; wb_mask = 4'hF;
        #1 chk1("a_ready", wb_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk1("a_req", ram_req, 1'b1);
        chk1("a_we", ram_we, 1'b1);
        chka("a_addr", ram_addr, 5'd3);
        chkd("a_wdata", ram_wdata, d_a5);
        chk1("a_busy_t1", busy, 1'b1);
        tick();
        chk1("a_busy_t2", busy, 1'b0);
        chk1("a_req_t2", ram_req, 1'b0);
        chkd("a_wdata_idle", ram_wdata, '0);
        chkd("a_ram3", ram[3], d_a5);

        // Back-pressure with grant low, then drain in order
        ram_gnt = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = d4; wb_mask = 4'hF;
        #1 chk1("bp_ready0", wb_ready, 1'b1);
        tick();
        wb_addr = 5'd5; wb_data = d5;
        #1 chk1("bp_ready1", wb_ready, 1'b1);
        chk1("bp_nogrant_req", ram_req, 1'b0);
        tick();
        wb_addr = 5'd6; wb_data = d6;
        #1 chk1("bp_full", wb_ready, 1'b0);
        tick();
        chk1("bp_full_hold", wb_ready, 1'b0);
        chk1("bp_hold_req", ram_req, 1'b0);
        ram_gnt = 1'b1;
        #1;
        chk1("bp_w0_req", ram_req, 1'b1);
        chka("bp_w0_addr", ram_addr, 5'd4);
        chk1("bp_w0_ready", wb_ready, 1'b0);
        tick();
        chk1("bp_ready_after_pop", wb_ready, 1'b1);
        chka("bp_w1_addr", ram_addr, 5'd5);
        tick();
        wb_valid = 1'b0;
        #1;
        chka("bp_w2_addr", ram_addr, 5'd6);
        chkd("bp_w2_data", ram_wdata, d6);
        tick();
        chk1("bp_busy_done", busy, 1'b0);
        chkd("bp_ram4", ram[4], d4);
        chkd("bp_ram5", ram[5], d5);
        chkd("bp_ram6", ram[6], d6);

        // Hazard tracking
        ram_gnt = 1'b0; haz_addr = 5'd9;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = d9; wb_mask = 4'hF;
        #1 chk1("haz_incoming", hazard, 1'b0);
        tick();
        wb_valid = 1'b0;
        #1 chk1("haz_queued", hazard, 1'b1);
        tick();
        chk1("haz_held", hazard, 1'b1);
        haz_addr = 5'd10;
        #1 chk1("haz_other_addr", hazard, 1'b0);
        haz_addr = 5'd9; ram_gnt = 1'b1;
        #1;
        chk1("haz_write_cycle", hazard, 1'b1);
        chka("haz_write_addr", ram_addr, 5'd9);
        tick();
        chk1("haz_after_write", hazard, 1'b0);
        haz_addr = 5'd31;

        // Back-to-back full writes under continuous grant
        wb_valid = 1'b1; wb_addr = 5'd20; wb_data = d20; wb_mask = 4'hF;
        tick();
        wb_addr = 5'd21; wb_data = d21;
        #1;
        chka("tp_w20", ram_addr, 5'd20);
        chk1("tp_ready20", wb_ready, 1'b1);
        tick();
        wb_addr = 5'd22; wb_data = d22;
        #1 chka("tp_w21", ram_addr, 5'd21);
        tick();
        wb_valid = 1'b0;
        #1 chka("tp_w22", ram_addr, 5'd22);
        tick();
        chk1("tp_idle", busy, 1'b0);
        chkd("tp_ram21", ram[21], d21);

        // Zero-mask entry
        wb_valid = 1'b1; wb_addr = 5'd14; wb_data = d14; wb_mask = 4'b0000;
        tick();
        wb_valid = 1'b0;
        #1;
`ifdef VRF_WB_MASK_EN
        chk1("z_req", ram_req, 1'b0);
        chk1("z_busy", busy, 1'b1);
        tick();
        chk1("z_busy_after", busy, 1'b0);
        chkd("z_ram14", ram[14], r14);
`else
        chk1("z_req", ram_req, 1'b1);
        chkd("z_wdata", ram_wdata, d14);
        tick();
        chk1("z_busy_after", busy, 1'b0);
        chkd("z_ram14", ram[14], d14);
`endif

        // Partial mask: RMW when masks are honoured, full write otherwise
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = d_ff; wb_mask = 4'b0101;
        tick();
        wb_valid = 1'b0;
        #1;
`ifdef VRF_WB_MASK_EN
        chk1("rmw_rd_req", ram_req, 1'b1);
        chk1("rmw_rd_we", ram_we, 1'b0);
        chka("rmw_rd_addr", ram_addr, 5'd7);
        chkd("rmw_rd_wdata", ram_wdata, '0);
        tick();
        ram_gnt = 1'b0;
        #1;
        chk1("rmw_latch_req", ram_req, 1'b0);
        chk1("rmw_latch_busy", busy, 1'b1);
        tick();
        ram_gnt = 1'b1;
        #1;
        chk1("rmw_wr_we", ram_we, 1'b1);
        chkd("rmw_wr_data", ram_wdata, merged7);
        tick();
        chkd("rmw_ram7", ram[7], merged7);
        chk1("rmw_done", busy, 1'b0);
`else
        chk1("pm_we", ram_we, 1'b1);
        chkd("pm_wdata", ram_wdata, d_ff);
        tick();
        chkd("pm_ram7", ram[7], d_ff);
`endif

        // Reset while an entry is pending and the grant is low
        haz_addr = 5'd12;
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = d12; wb_mask = 4'b0011;
`ifdef VRF_WB_MASK_EN
        ram_gnt = 1'b1;
        tick();
        wb_valid = 1'b0;
        tick();
        ram_gnt = 1'b0;
        tick();
`else
        ram_gnt = 1'b0;
        tick();
        wb_valid = 1'b0;
        tick();
`endif
        chk1("ra_busy_pre", busy, 1'b1);
        chk1("ra_req_pre", ram_req, 1'b0);
        wr_snap = wr_cnt;
        rst = 1'b1;
        #1;
        chk_reset_outputs("ra");
        tick();
        rst = 1'b0;
        ram_gnt = 1'b1;
        tick();
        tick();
        chk1("ra_idle", busy, 1'b0);
        chkd("ra_ram12", ram[12], r12);
        n_vec++;
        assert (wr_cnt == wr_snap) else begin
            n_err++;
            $error("FAIL ra_no_write: observed %0d writes expected %0d", wr_cnt, wr_snap);
        end

        chk1("req_only_with_grant", bad_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
